// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and types for the SRAM port arbiter slice.
package sram_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 2;
    localparam int ADDR_WIDTH_DEF = 4;

    // Grant-to-response latency of a read, in clock cycles.
    localparam int READ_LATENCY = 2;

    // Response tag carried on rsp0_id.
    typedef enum logic {
        REQ_ID_M0 = 1'b0,
        REQ_ID_M1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester, response and macro-side signals of the SRAM port arbiter.
// The master modport is the environment (requesters plus macro); slave is the arbiter.
interface sram_port_arbiter_if
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  m0_valid, m1_valid, m2_valid;
    logic                  m0_we, m1_we;
    logic [ADDR_WIDTH-1:0] m0_addr, m1_addr, m2_addr;
    logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
    logic                  m0_ready, m1_ready, m2_ready;
    logic                  rsp0_valid, rsp0_id, rsp2_valid;
    logic [DATA_WIDTH-1:0] rsp0_data, rsp2_data;
    logic                  csb0, web0, csb1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] din0, dout0, dout1;

    modport master (
        output m0_valid, m1_valid, m2_valid, m0_we, m1_we,
        output m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata,
        output dout0, dout1,
        input  m0_ready, m1_ready, m2_ready,
        input  rsp0_valid, rsp0_id, rsp0_data, rsp2_valid, rsp2_data,
        input  csb0, web0, addr0, din0, csb1, addr1
    );

    modport slave (
        input  m0_valid, m1_valid, m2_valid, m0_we, m1_we,
        input  m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata,
        input  dout0, dout1,
        output m0_ready, m1_ready, m2_ready,
        output rsp0_valid, rsp0_id, rsp0_data, rsp2_valid, rsp2_data,
        output csb0, web0, addr0, din0, csb1, addr1
    );
endinterface

// File: rtl/sram_port_arbiter_arb.sv
// Two-way round-robin arbiter: a grant hands priority to the other requester.
module sram_rr_arb (
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    // prio_q = 0 favours requester 0, 1 favours requester 1
    logic prio_q, prio_d;

    // Pick the favoured requester on contention, otherwise whoever is asking
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !prio_q)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // Priority moves away from whichever requester was just accepted
    always_comb begin
        prio_d = prio_q;
        if (accept && gnt[0]) begin
            prio_d = 1'b1;
        end else if (accept && gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    // Priority register, requester 0 first out of reset
    always_ff @(posedge clk) begin
        if (!rstb) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the RW port of a dual-port SRAM macro between m0/m1 and gives m2 the R port.
// Macro reads land on dout one cycle after the access; the arbiter registers them once
// more, so every read answers two cycles after its grant.
module sram_port_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input logic                clk,
    input logic                rstb,
    sram_port_arbiter_if.slave bus
);
    logic [1:0]            arb_req, arb_gnt;
    logic                  granted, sel_m1, cmd_we, collision, m2_go;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // In-flight read tags (access cycle -> macro output cycle)
    logic    rd0_q, rd0_d, rd2_q, rd2_d;
    req_id_e id0_q, id0_d;

    // Response registers
    logic                  rsp0_valid_q, rsp0_valid_d, rsp2_valid_q, rsp2_valid_d;
    req_id_e               rsp0_id_q, rsp0_id_d;
    logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d, rsp2_data_q, rsp2_data_d;

    // Requests are masked during reset so nothing is granted or touches the macro
    assign arb_req = {bus.m1_valid, bus.m0_valid} & {2{rstb}};

    sram_rr_arb u_arb (
        .clk    (clk),
        .rstb   (rstb),
        .req    (arb_req),
        .accept (granted),
        .gnt    (arb_gnt)
    );

    // Mux the granted command and decide whether m2 may use the R port this cycle
    always_comb begin
        granted   = |arb_gnt;
        sel_m1    = arb_gnt[1];
        cmd_we    = sel_m1 ? bus.m1_we    : bus.m0_we;
        cmd_addr  = sel_m1 ? bus.m1_addr  : bus.m0_addr;
        cmd_wdata = sel_m1 ? bus.m1_wdata : bus.m0_wdata;
        // Reading the word being written this cycle would return stale data
        collision = granted && cmd_we && bus.m2_valid && (bus.m2_addr == cmd_addr);
        m2_go     = rstb && bus.m2_valid && !collision;
    end

    assign bus.m0_ready = arb_gnt[0];
    assign bus.m1_ready = arb_gnt[1];
    assign bus.m2_ready = m2_go;
    assign bus.csb0     = !granted;
    assign bus.web0     = !(granted && cmd_we);
    assign bus.addr0    = cmd_addr;
    assign bus.din0     = cmd_wdata;
    assign bus.csb1     = !m2_go;
    assign bus.addr1    = bus.m2_addr;

    // Tag reads at grant; capture macro data one cycle later, holding it otherwise
    always_comb begin
        rd0_d        = granted && !cmd_we;
        id0_d        = sel_m1 ? REQ_ID_M1 : REQ_ID_M0;
        rd2_d        = m2_go;
        rsp0_valid_d = rd0_q;
        rsp0_id_d    = rsp0_id_q;
        rsp0_data_d  = rsp0_data_q;
        rsp2_valid_d = rd2_q;
        rsp2_data_d  = rsp2_data_q;
        if (rd0_q) begin
            rsp0_id_d   = id0_q;
            rsp0_data_d = bus.dout0;
        end
        if (rd2_q) begin
            rsp2_data_d = bus.dout1;
        end
    end

    // Pipeline registers; reset drops every read still in flight
    always_ff @(posedge clk) begin
        if (!rstb) begin
            rd0_q        <= 1'b0;
            id0_q        <= REQ_ID_M0;
            rd2_q        <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp0_id_q    <= REQ_ID_M0;
            rsp0_data_q  <= '0;
            rsp2_valid_q <= 1'b0;
            rsp2_data_q  <= '0;
        end else begin
            rd0_q        <= rd0_d;
            id0_q        <= id0_d;
            rd2_q        <= rd2_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_id_q    <= rsp0_id_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp2_valid_q <= rsp2_valid_d;
            rsp2_data_q  <= rsp2_data_d;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_id    = rsp0_id_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp2_valid = rsp2_valid_q;
    assign bus.rsp2_data  = rsp2_data_q;
endmodule
